sdiv_2c_seq: RTL



---
 rtl/sdiv_2c_seq_pkg.sv | 10 +
 rtl/sdiv_2c_seq_neg_2c.sv | 10 +
 rtl/sdiv_2c_seq.sv | 91 +++++++++
 3 files changed

// File: rtl/sdiv_2c_seq_pkg.sv
// sdiv_pkg: shared types and constants for the sequential signed divider.
package sdiv_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    localparam int SDIV_W = 4;
    localparam logic DBZ_Q_FILL = 1'b1;
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction
    localparam int SDIV_CW = cnt_w(SDIV_W);
endpackage

// File: rtl/sdiv_2c_seq_neg_2c.sv
// neg_2c: conditional two's-complement negate.
module neg_2c #(
    parameter int W = 4
) (
    input  logic [W-1:0] src,
    input  logic         neg,
    output logic [W-1:0] res
);
    always_comb res = neg ? ~src + W'(1) : src;
endmodule

// File: rtl/sdiv_2c_seq.sv
// sdiv_2c_seq: signed restoring divider, one quotient bit per clock, then sign fix-up.
module sdiv_2c_seq
    import sdiv_pkg::*;
#(
    parameter int W = SDIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);
    localparam int CW = cnt_w(W);
    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a, r, dd_abs, dv_abs, q_fix, r_fix, diff;
    logic [W:0]    b, rs;
    logic          sign_q, sign_r, dbz_p, ovf_p, borrow;
    // W-bit negate of the most-negative value reads back as 2^(W-1) unsigned.
    neg_2c #(.W(W)) u_abs_dd (.src(dividend), .neg(dividend[W-1]), .res(dd_abs));
    neg_2c #(.W(W)) u_abs_dv (.src(divisor),  .neg(divisor[W-1]),  .res(dv_abs));
    neg_2c #(.W(W)) u_fix_q  (.src(a),        .neg(sign_q),        .res(q_fix));
    neg_2c #(.W(W)) u_fix_r  (.src(r),        .neg(sign_r),        .res(r_fix));
    assign rs     = {r, a[W-1]};
    assign borrow = rs < b;
    assign diff   = W'(rs - b);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            a           <= '0;
            b           <= '0;
            r           <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dbz_p       <= 1'b0;
            ovf_p       <= 1'b0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= CALC;
                    cnt    <= CW'(W - 1);
                    a      <= dd_abs;
                    b      <= {1'b0, dv_abs};
                    r      <= '0;
                    sign_q <= dividend[W-1] ^ divisor[W-1];
                    sign_r <= dividend[W-1];
                    dbz_p  <= divisor == '0;
                    ovf_p  <= (dividend == {1'b1, {(W-1){1'b0}}}) && (divisor == '1);
                    ready  <= 1'b0;
                    busy   <= 1'b1;
                end
                CALC: begin
                    // Quotient bits fill a from the LSB as dividend bits leave the MSB.
                    r     <= borrow ? rs[W-1:0] : diff;
                    a     <= {a[W-2:0], ~borrow};
                    cnt   <= cnt - CW'(1);
                    state <= (cnt == '0) ? FIX : CALC;
                end
                FIX: begin
                    quotient    <= dbz_p ? {W{DBZ_Q_FILL}} : q_fix;
                    remainder   <= r_fix;
                    div_by_zero <= dbz_p;
                    overflow    <= ovf_p;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
